// File: rtl/twos_complement_serial_fsm_pkg.sv
// Shared definitions for the bit-serial two's-complement converter.
//   tc_state_e : FSM state encoding (S_PASS / S_INVERT)
//   cnt_width  : bit width of the word-position counter for a given WORD_LEN
package twos_comp_pkg;

  typedef enum logic {
    S_PASS   = 1'b0,  // no 1 seen yet in the current word
    S_INVERT = 1'b1   // a 1 has already been consumed
  } tc_state_e;

  // Counter width: clog2(word_len), never below one bit (covers 0 and 1).
  function automatic int unsigned cnt_width(input int unsigned word_len);
    if (word_len <= 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(word_len);
    end
  endfunction

endpackage

// File: rtl/twos_complement_serial_fsm_counter.sv
// Word-position counter for the serial converter.
// Counts bits 0..WORD_LEN-1 and wraps. last_bit is high while the
// current bit is the final bit of a word. With WORD_LEN=0 (unbounded
// stream) there is no counter and last_bit is tied low.
//   clk      : system clock
//   reset    : synchronous active-high reset, clears the count
//   last_bit : current bit is the last bit of the word
module serial_word_counter
  import twos_comp_pkg::*;
#(
  parameter int unsigned WORD_LEN = 0
) (
  input  logic clk,
  input  logic reset,
  output logic last_bit
);

  localparam int unsigned CW = cnt_width(WORD_LEN);

  generate
    if (WORD_LEN == 0) begin : g_unbounded
      // Clock and reset have no work to do without word boundaries.
      logic unused_s;
      assign unused_s = clk ^ reset;
      assign last_bit = 1'b0;
    end else begin : g_counted
      localparam logic [CW-1:0] LAST_IDX = CW'(WORD_LEN - 1);
      logic [CW-1:0] count_r;

      // Bit-position counter: clears on reset, wraps after the last bit.
      always_ff @(posedge clk) begin
        if (reset) begin
          count_r <= '0;
        end else if (count_r == LAST_IDX) begin
          count_r <= '0;
        end else begin
          count_r <= count_r + CW'(1'b1);
        end
      end

      assign last_bit = (count_r == LAST_IDX);
    end
  endgenerate

endmodule

// File: rtl/twos_complement_serial_fsm.sv
// Bit-serial two's-complement negator, LSB first.
// Passes bits unchanged up to and including the first 1 of a word and
// inverts every later bit. Output is Mealy: it follows `in` within the
// same cycle, using the state left by the previous edge.
//   WORD_LEN : 0 = unbounded stream (only reset starts a new word),
//              N>0 = automatic restart after every N bits
//   clk      : system clock
//   reset    : synchronous active-high reset (state only, out stays live)
//   in       : serial operand bit, LSB first
//   out      : serial negated bit for the current `in`
module twos_complement_serial_fsm
  import twos_comp_pkg::*;
#(
  parameter int unsigned WORD_LEN = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  tc_state_e state_r;
  tc_state_e next_state_s;
  logic      last_bit_s;

  serial_word_counter #(
    .WORD_LEN(WORD_LEN)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .last_bit (last_bit_s)
  );

  // Next-state logic: a word boundary overrides the normal transition so
  // the next bit starts a fresh word.
  always_comb begin
    next_state_s = state_r;
    if (last_bit_s) begin
      next_state_s = S_PASS;
    end else begin
      case (state_r)
        S_PASS: begin
          if (in) begin
            next_state_s = S_INVERT;
          end else begin
            next_state_s = S_PASS;
          end
        end
        S_INVERT: next_state_s = S_INVERT;
        default:  next_state_s = S_PASS;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_PASS;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Mealy output: complement once the first 1 has gone by.
  assign out = (state_r == S_INVERT) ? ~in : in;

endmodule

// File: tb/tb_twos_complement_serial_fsm.sv
module tb_twos_complement_serial_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic out0, out4, out1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  twos_complement_serial_fsm #(.WORD_LEN(0)) dut0 (
    .clk(clk), .reset(rst), .in(din), .out(out0));
  twos_complement_serial_fsm #(.WORD_LEN(4)) dut4 (
    .clk(clk), .reset(rst), .in(din), .out(out4));
  twos_complement_serial_fsm #(.WORD_LEN(1)) dut1 (
    .clk(clk), .reset(rst), .in(din), .out(out1));

  typedef struct {
    logic rst;
    logic din;
    logic e0;   // expected out, WORD_LEN=0
    logic e4;   // expected out, WORD_LEN=4
    logic e1;   // expected out, WORD_LEN=1
    logic chk;  // 0 where state is still undefined
  } vec_t;

  localparam int NV = 38;
  vec_t vecs[NV];

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    // rst din e0 e4 e1 chk
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // first reset
    // 20 = 0,0,1,0,1 -> 12 = 0,0,1,1,0 (unbounded)
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    // reset while inverting: out still from old state
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    // all zeros
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    // reset from S_PASS: out = in
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    // -1 = 1,1,1,1 -> +1 = 1,0,0,0
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    // 0,1,0,0 then reset then 0,1
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[21] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[23] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    // reset, then 0,1,0,0,1,0,0,0 with no reset between words
    vecs[24] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[26] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[27] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[28] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[29] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[30] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[31] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[32] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    // reset, then most-negative 4-bit value 0,0,0,1 -> unchanged
    vecs[33] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[34] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[35] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[36] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[37] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst;
      din = vecs[i].din;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("row%0d_wl0", i), out0, vecs[i].e0);
        check($sformatf("row%0d_wl4", i), out4, vecs[i].e4);
        check($sformatf("row%0d_wl1", i), out1, vecs[i].e1);
      end
    end

    // Mid-cycle toggles: dut0 is in S_INVERT, dut4 restarted at its
    // word boundary, dut1 always passes. No clock edge in between.
    @(posedge clk);
    #1 rst = 1'b0; din = 1'b0;
    #1;
    check("toggle0_wl0", out0, 1'b1);
    check("toggle0_wl4", out4, 1'b0);
    din = 1'b1;
    #1;
    check("toggle1_wl0", out0, 1'b0);
    check("toggle1_wl4", out4, 1'b1);
    check("toggle1_wl1", out1, 1'b1);
    din = 1'b0;
    #1;
    check("toggle2_wl0", out0, 1'b1);
    check("toggle2_wl1", out1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/twos_complement_serial_fsm.md
Name: twos_complement_serial_fsm

Overview:
- Bit-serial two's-complement converter. The operand arrives on `in`, one bit per `clk` cycle, least-significant bit first; `out` gives the negated value in the same cycle.
- Algorithm: pass bits unchanged up to and including the first 1; invert every bit after it.
- Sits on a serial datapath between a shift-out source and a shift-in sink. No handshake: every clock edge consumes one bit.

Parameters:
- WORD_LEN, default 0, serial word length in bits.
  - 0 = unbounded stream; only `reset` starts a new word.
  - N>0 = FSM auto-restarts after every N bits.
  - Legal range 0..65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- in  input  1  serial operand bit, LSB first; sampled on each rising clk edge.
- out  output  1  serial two's-complement result bit for the current `in` (combinational, Mealy).

Behaviour:
- States:
  - S_PASS: no 1 seen yet in the current word.
  - S_INVERT: a 1 has already been consumed.
- Output (Mealy, zero latency):
  - out = in when state = S_PASS.
  - out = ~in when state = S_INVERT.
  - `out` tracks `in` combinationally within the cycle.
- Transitions at rising clk edge, in priority order:
  - reset=1 -> S_PASS; bit counter cleared to 0.
  - WORD_LEN>0 and the counter equals WORD_LEN-1 (last bit of word) -> S_PASS, counter 0. The current bit's `out` is still computed from the pre-edge state.
  - S_PASS and in=1 -> S_INVERT.
  - S_PASS and in=0 -> S_PASS.
  - S_INVERT -> S_INVERT for any `in`.
  - When WORD_LEN>0, the counter increments on every non-reset edge.
- Reset:
  - Reset is state-only. While reset is high, `out` is still computed from the current state.
  - After the first reset edge, out = in.
  - Before any reset, state is undefined; the bench must apply reset first.
  - Reset mid-word aborts the word; the next bit is treated as the LSB of a new word.
- Boundary values:
  - All-zero word: out = in = 0 for every bit; state stays S_PASS (−0 = 0).
  - Most-negative value (1 followed by zeros, MSB last): output equals input (wrap, no overflow flag).
- With WORD_LEN=1: every edge returns to S_PASS, so out = in always.
- Counter width: clog2(WORD_LEN) bits, minimum 1. The counter is absent or unused when WORD_LEN=0.
- No X-propagation guard: if `in` is X, `out` is X, and the state is unchanged only when in S_INVERT.

Decomposition:
- Shared package `twos_comp_pkg` holds:
  - State enum `tc_state_e` {S_PASS=1'b0, S_INVERT=1'b1}.
  - Localparam helper for the counter width.
- Optional sub-module `serial_word_counter`:
  - Parameterised by WORD_LEN.
  - Outputs `last_bit`.
  - Tied to 0 when WORD_LEN=0.
- Main FSM: one next-state block, one state register, one output assign.

Test Plan:
- Reset then stream 0,0,1,0,1 (value 20, 5-bit, LSB first; one bit per cycle, `in` changing at the clock edge) -> out = 0,0,1,1,0 (value 12 = −20 mod 32).
- Reset then stream 0,0,0,0 -> out = 0,0,0,0; state stays S_PASS.
- Reset then 1,1,1,1 (−1) -> out = 1,0,0,0 (+1).
- Stream 0,1,0,0 then assert reset for one cycle, then stream 0,1 -> after reset, out = 0,1 (fresh word, not inverted).
- WORD_LEN=4: stream 0,1,0,0 then 1,0,0,0 without reset -> out = 0,1,1,1 then 1,1,1,1 (auto-restart at the word boundary).
- Mid-cycle `in` toggle while in S_INVERT -> `out` toggles in the same delta as the complement; no clock edge is needed.
